color_jitter: RTL and testbench
===============================

// Module: color_jitter
// PURPOSE
// - Augmentation stage directly downstream of the resized-crop reader.
// - Consumes its 8-bit pixel stream (pixel/valid, stall via interrupt).
// - Applies per-image brightness/contrast jitter, buffers results in a FIFO.
// - Presents them to the next consumer on a valid/ready stream with end-of-image marking.
// PARAMETERS
// - PIXELS_PER_IMAGE  1024  pixels per cropped image (32x32); counter width = clog2(PIXELS_PER_IMAGE+1)
// - FIFO_DEPTH        16    output FIFO entries (power of 2, >= 8)
// - SKID              4     free entries kept when interrupt_o asserts; covers upstream BRAM read latency
// PORTS
// - clk            in   1  single clock, rising edge
// - reset          in   1  asynchronous, active-low; all state cleared while low
// - img_start      in   1  one-cycle pulse, same pulse that starts the upstream crop
// - pixel_i        in   8  pixel from crop stage
// - pixel_valid_i  in   1  pixel_i valid this cycle; always accepted unless FIFO full (then dropped)
// - interrupt_o    out  1  stall request to crop stage
// - brightness_i   in   8  signed offset, -128..127; sampled at image start
// - contrast_i     in   8  unsigned Q1.7 gain, 128 = 1.0; sampled at image start
// - pixel_o        out  8  jittered pixel (FIFO head)
// - pixel_valid_o  out  1  FIFO non-empty
// - pixel_ready_i  in   1  consumer accepts pixel_o when high together with pixel_valid_o
// - pixel_last_o   out  1  qualifies pixel_o as last pixel of the image
// - image_done_o   out  1  one-cycle pulse after the last pixel is handed off
// - overflow_o     out  1  sticky: a valid pixel arrived while FIFO full; cleared by reset or img_start
// - busy_o         out  1  high in LOAD/RUN/DRAIN
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, FSM IDLE, brightness=0, contrast=128, counters 0.
// - FSM: IDLE -img_start-> LOAD (1 cyc) -> RUN -(PIXELS_PER_IMAGE pixels accepted)-> DRAIN
//   -(last pixel handed off)-> IDLE, with image_done_o pulse.
// - LOAD latches brightness/contrast factors and clears in_cnt, out_cnt and overflow_o.
// - pixel_valid_i is ignored in IDLE/LOAD/DRAIN.
// - img_start outside IDLE: ignored; no state change.
// - Datapath, 2-stage pipe:
//   - S1: d = pix - 128 (9b signed); p = d*contrast (17b signed).
//   - S2: y = (p >>> 7) + 128 + brightness; clamp to [0,255]; write FIFO with last flag.
//   - Total latency pixel_valid_i -> pixel_valid_o = 3 cycles into an empty FIFO.
//   - contrast 128 and brightness 0 give the identity.
// - Occupancy = FIFO count + valid pipeline stages.
//   - interrupt_o registered high when occupancy >= FIFO_DEPTH-SKID.
//   - interrupt_o low when occupancy < FIFO_DEPTH-SKID.
// - FIFO full on an S2 write: pixel dropped, overflow_o set, in_cnt still increments.
//   This keeps image framing intact.
// - Simultaneous FIFO read and write when full: the write succeeds.
// - Simultaneous read and write when empty: no bypass; data appears next cycle.
// - pixel_last_o is set on the FIFO entry written for in_cnt == PIXELS_PER_IMAGE-1.
// - DRAIN->IDLE on the cycle pixel_valid_o & pixel_ready_i & pixel_last_o.
//   image_done_o pulses the following cycle.
// - pixel_o, pixel_valid_o and pixel_last_o stay stable while pixel_valid_o=1 and pixel_ready_i=0.
// - Reset mid-image: everything discards immediately, including FIFO contents and the pipe.
//   No image_done_o.
// CONFIGURATION
// - JITTER_LFSR_EN defined:
//   - LOAD takes factors from an internal 16-bit Galois LFSR (poly 0xB400, seed 0xACE1 at reset).
//   - The LFSR steps once per LOAD.
//   - brightness = {{3{lfsr[4]}}, lfsr[4:0]}, range -16..15.
//   - contrast = 112 + lfsr[12:8], range 112..143.
//   - brightness_i and contrast_i are unused.
// - JITTER_LFSR_EN undefined: factors are brightness_i/contrast_i sampled in LOAD; no LFSR logic.
// TESTING
// - Identity: brightness_i=0, contrast_i=128, pixels 0..255 ramp, ready=1.
//   -> pixel_o equals input, 3-cycle latency.
// - Clamp: brightness_i=100, contrast_i=255, pixel 200.
//   -> 255; pixel 10 with brightness_i=-128 -> 0; pixel 128, contrast 0, brightness 5 -> 133.
// - Backpressure: pixel_ready_i=0, continuous pixel_valid_i.
//   -> interrupt_o high once occupancy reaches 12 (DEPTH 16, SKID 4).
//   -> 3 more pixels in flight accepted; overflow_o stays 0; FIFO holds 16 max.
// - Framing: PIXELS_PER_IMAGE=16, stall bursts mid-image.
//   -> pixel_last_o exactly on 16th output; image_done_o one cycle after its handshake.
//   -> busy_o low after.
// - Overflow/reset: force valid into full FIFO.
//   -> overflow_o=1, count still 16; assert reset mid-image -> all outputs 0, next img_start runs clean.
// - JITTER_LFSR_EN: two consecutive images.
//   -> factors match the LFSR model from seed 0xACE1, and differ between the two images.

Source files
------------

// File: rtl/color_jitter.sv
`timescale 1ns/1ps
// color_jitter: per-image brightness/contrast jitter on an 8-bit pixel stream, buffered in a FIFO.
// Build option JITTER_LFSR_EN: per-image factors come from an internal LFSR instead of the inputs.
module color_jitter #(
    parameter int unsigned PIXELS_PER_IMAGE = 1024,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned SKID             = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       img_start,
    input  logic [7:0] pixel_i,
    input  logic       pixel_valid_i,
    output logic       interrupt_o,
    input  logic [7:0] brightness_i,
    input  logic [7:0] contrast_i,
    output logic [7:0] pixel_o,
    output logic       pixel_valid_o,
    input  logic       pixel_ready_i,
    output logic       pixel_last_o,
    output logic       image_done_o,
    output logic       overflow_o,
    output logic       busy_o
);

    localparam int unsigned CntW  = $clog2(PIXELS_PER_IMAGE + 1);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned FcntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} state_e;

    state_e state_q, state_d;
    logic load, accept, busy;

    logic [CntW-1:0] in_cnt_q, in_cnt_d;
    logic            last_in;
    logic [7:0]      bright_q, bright_d, contrast_q, contrast_d;

    logic               s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic signed [8:0]  s1_diff;
    logic signed [16:0] s1_p_q, s1_p_d;
    logic signed [16:0] s2_shift, s2_sum;
    logic               s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [7:0]         s2_pix_q, s2_pix_d;

    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [8:0]       mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FcntW-1:0] cnt_q, cnt_d;
    logic             fifo_full, fifo_rd, fifo_wr, fifo_drop;
    logic [8:0]       head;
    int               occ_next;

    logic overflow_q, overflow_d, interrupt_q, interrupt_d, done_q, done_d;

`ifdef JITTER_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (img_start) state_d = StLoad;
            StLoad:  state_d = StRun;
            StRun:   if (accept && last_in) state_d = StDrain;
            StDrain: if (fifo_rd && head[8]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load   = (state_q == StLoad);
        accept = (state_q == StRun) && pixel_valid_i;
        busy   = (state_q != StIdle);
    end

    always_comb begin
        last_in  = (in_cnt_q == CntW'(PIXELS_PER_IMAGE - 1));
        in_cnt_d = in_cnt_q;
        if (load) begin
            in_cnt_d = '0;
        end else if (accept) begin
            in_cnt_d = in_cnt_q + CntW'(1);
        end

        bright_d   = bright_q;
        contrast_d = contrast_q;
`ifdef JITTER_LFSR_EN
        lfsr_d = lfsr_q;
        if (load) begin
            bright_d   = {{3{lfsr_q[4]}}, lfsr_q[4:0]};
            contrast_d = 8'd112 + {3'b000, lfsr_q[12:8]};
            lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
`else
        if (load) begin
            bright_d   = brightness_i;
            contrast_d = contrast_i;
        end
`endif
    end

    // Two-stage arithmetic: centre and scale, then shift, offset and clamp
    always_comb begin
        s1_valid_d = accept;
        s1_last_d  = last_in;
        s1_diff    = $signed({1'b0, pixel_i}) - 9'sd128;
        s1_p_d     = $signed({{8{s1_diff[8]}}, s1_diff}) * $signed({9'd0, contrast_q});

        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_shift   = s1_p_q >>> 7;
        s2_sum     = s2_shift + 17'sd128 + $signed({{9{bright_q[7]}}, bright_q});
        if (s2_sum < 17'sd0) begin
            s2_pix_d = 8'd0;
        end else if (s2_sum > 17'sd255) begin
            s2_pix_d = 8'd255;
        end else begin
            s2_pix_d = s2_sum[7:0];
        end
    end

    // FIFO: a read frees the slot so a write into a full FIFO still lands
    always_comb begin
        head      = mem_q[rd_ptr_q];
        fifo_full = (cnt_q == FcntW'(FIFO_DEPTH));
        fifo_rd   = (cnt_q != '0) && pixel_ready_i;
        fifo_wr   = s2_valid_q && (!fifo_full || fifo_rd);
        fifo_drop = s2_valid_q && fifo_full && !fifo_rd;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (fifo_wr) begin
            mem_d[wr_ptr_q] = {s2_last_q, s2_pix_q};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (fifo_wr && !fifo_rd) begin
            cnt_d = cnt_q + FcntW'(1);
        end else if (!fifo_wr && fifo_rd) begin
            cnt_d = cnt_q - FcntW'(1);
        end

        // Registered stall tracks the occupancy the next cycle will see
        occ_next    = int'(cnt_d) + int'(s1_valid_d) + int'(s2_valid_d);
        interrupt_d = (occ_next >= int'(FIFO_DEPTH - SKID));

        overflow_d = overflow_q;
        if (load) overflow_d = 1'b0;
        if (fifo_drop) overflow_d = 1'b1;

        done_d = (state_q == StDrain) && fifo_rd && head[8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_cnt_q    <= '0;
            bright_q    <= 8'd0;
            contrast_q  <= 8'd128;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_p_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_pix_q    <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            interrupt_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef JITTER_LFSR_EN
            lfsr_q      <= 16'hACE1;
`endif
        end else begin
            in_cnt_q    <= in_cnt_d;
            bright_q    <= bright_d;
            contrast_q  <= contrast_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_p_q      <= s1_p_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_pix_q    <= s2_pix_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
            interrupt_q <= interrupt_d;
            done_q      <= done_d;
`ifdef JITTER_LFSR_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    always_comb begin
        pixel_valid_o = (cnt_q != '0);
        pixel_o       = pixel_valid_o ? head[7:0] : 8'd0;
        pixel_last_o  = pixel_valid_o && head[8];
        interrupt_o   = interrupt_q;
        image_done_o  = done_q;
        overflow_o    = overflow_q;
        busy_o        = busy;
    end

endmodule

// File: tb/tb_color_jitter.sv
`timescale 1ns/1ps
// tb_color_jitter: randomized images checked against a transaction-level model of the jitter stage.
module tb_color_jitter;

    localparam int PPI   = 24;
    localparam int DEPTH = 16;
    localparam int SKID  = 4;

    logic       clk = 1'b0, reset = 1'b0, img_start = 1'b0;
    logic [7:0] pixel_i = 8'd0, brightness_i = 8'd0, contrast_i = 8'd128;
    logic       pixel_valid_i = 1'b0, pixel_ready_i = 1'b0;
    logic       interrupt_o, pixel_valid_o, pixel_last_o, image_done_o, overflow_o, busy_o;
    logic [7:0] pixel_o;

    color_jitter #(.PIXELS_PER_IMAGE(PPI), .FIFO_DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk(clk), .reset(reset), .img_start(img_start), .pixel_i(pixel_i),
        .pixel_valid_i(pixel_valid_i), .interrupt_o(interrupt_o), .brightness_i(brightness_i),
        .contrast_i(contrast_i), .pixel_o(pixel_o), .pixel_valid_o(pixel_valid_o),
        .pixel_ready_i(pixel_ready_i), .pixel_last_o(pixel_last_o), .image_done_o(image_done_o),
        .overflow_o(overflow_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Jitter rule: y = floor((pix-128)*c/128) + 128 + b, clamped to 0..255
    function automatic int jitter(input int pix, input int b, input int c);
        int y;
        y = (((pix - 128) * c) >>> 7) + 128 + b;
        if (y < 0) y = 0;
        if (y > 255) y = 255;
        return y;
    endfunction

    typedef enum {MIdle, MLoad, MRun, MDrain} mstate_t;
    mstate_t m_st = MIdle, nxt;
    int   m_b = 0, m_c = 128, m_n = 0, acc = 0, hs = 0, hs_img = 0, cyc = 0, first_acc = 0, e_val;
    bit   done_exp = 0, sb_on = 1, prev_stall = 0, lat_armed = 0;
    logic [7:0] prev_pix, last_hs_pix = 8'd0, lb8;
    logic prev_last;
    int   exp_q[$];
`ifdef JITTER_LFSR_EN
    logic [15:0] m_lfsr = 16'hACE1;
`endif

    // Model + compare: check outputs from the last edge, then account for the coming edge
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            m_st = MIdle; exp_q.delete(); acc = 0; hs = 0; m_n = 0;
            done_exp = 0; prev_stall = 0; lat_armed = 0;
`ifdef JITTER_LFSR_EN
            m_lfsr = 16'hACE1;
`endif
        end else begin
            check("busy", int'(busy_o), int'(m_st != MIdle));
            check("image_done", int'(image_done_o), int'(done_exp));
            if (sb_on) begin
                check("interrupt", int'(interrupt_o), int'((acc - hs) >= DEPTH - SKID));
                check("overflow", int'(overflow_o), 0);
            end
            if (prev_stall) begin
                check("hold_valid", int'(pixel_valid_o), 1);
                check("hold_pixel", int'(pixel_o), int'(prev_pix));
                check("hold_last", int'(pixel_last_o), int'(prev_last));
            end
            if (lat_armed && pixel_valid_o) begin
                check("latency", cyc - first_acc, 3);
                lat_armed = 0;
            end
            done_exp   = 0;
            prev_stall = pixel_valid_o && !pixel_ready_i;
            prev_pix   = pixel_o;
            prev_last  = pixel_last_o;
            nxt = m_st;
            if (pixel_valid_o && pixel_ready_i) begin
                hs++; hs_img++; last_hs_pix = pixel_o;
                if (sb_on) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_output", exp_q.size(), 1);
                    end else begin
                        e_val = exp_q.pop_front();
                        check("pixel", int'(pixel_o), e_val % 256);
                        check("last", int'(pixel_last_o), e_val / 256);
                    end
                end
                if (pixel_last_o && m_st == MDrain) begin
                    nxt = MIdle; done_exp = 1;
                end
            end
            case (m_st)
                MIdle: if (img_start) begin
                    nxt = MLoad; m_n = 0; hs_img = 0;
`ifdef JITTER_LFSR_EN
                    lb8 = {{3{m_lfsr[4]}}, m_lfsr[4:0]};
                    m_b = int'($signed(lb8));
                    m_c = 112 + int'(m_lfsr[12:8]);
                    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`else
                    lb8 = brightness_i;
                    m_b = int'($signed(lb8));
                    m_c = int'(contrast_i);
`endif
                end
                MLoad: nxt = MRun;
                MRun: if (pixel_valid_i) begin
                    if (m_n == 0) begin first_acc = cyc; lat_armed = 1; end
                    exp_q.push_back(jitter(int'(pixel_i), m_b, m_c) + ((m_n == PPI - 1) ? 256 : 0));
                    acc++; m_n++;
                    if (m_n == PPI) nxt = MDrain;
                end
                default: ;
            endcase
            m_st = nxt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; img_start = 1'b0; pixel_valid_i = 1'b0; pixel_ready_i = 1'b0;
        #1;
        check("rst_pixel", int'(pixel_o), 0);
        check("rst_valid", int'(pixel_valid_o), 0);
        check("rst_last", int'(pixel_last_o), 0);
        check("rst_done", int'(image_done_o), 0);
        check("rst_overflow", int'(overflow_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_interrupt", int'(interrupt_o), 0);
        tick(); tick();
        reset = 1'b1; sb_on = 1;
        tick();
    endtask

    // mode: 0 random, 1 ramp, 2 constant pixel, 3 backpressure, 4 overflow, 5 reset mid-image
    task automatic run_image(input int mode, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] base, input int lit);
        int sent = 0, guard = 0;
        bit [3:0] ih = 4'b0;
        bit allow, want;
        if (mode == 4) sb_on = 0;
        brightness_i = b; contrast_i = c; img_start = 1'b1;
        tick();
        img_start = 1'b0; pixel_valid_i = 1'($urandom_range(0, 1)); pixel_i = 8'($urandom);
        tick();
        brightness_i = 8'($urandom); contrast_i = 8'($urandom);
        while (sent < PPI && guard < 2000) begin
            if (mode == 3 && guard == 38) begin
                check("bp_accepted", sent, DEPTH - SKID + 3);
                check("bp_interrupt", int'(interrupt_o), 1);
            end
            case (mode)
                1, 2:    pixel_ready_i = 1'b1;
                3:       pixel_ready_i = (guard >= 40);
                4, 5:    pixel_ready_i = 1'b0;
                default: pixel_ready_i = ($urandom_range(0, 3) != 0);
            endcase
            allow = (mode == 4) || !ih[3];
            want  = (mode != 0) || ($urandom_range(0, 3) != 0);
            pixel_valid_i = allow && want;
            pixel_i = (mode == 1 || mode == 4) ? 8'(base + 8'(sent)) :
                      (mode == 2) ? base : 8'($urandom);
            img_start = (mode == 0) && ($urandom_range(0, 15) == 0);
            if (pixel_valid_i) sent++;
            tick();
            ih = {ih[2:0], interrupt_o};
            guard++;
            if (mode == 5 && sent == 10) break;
        end
        pixel_valid_i = 1'b0; img_start = 1'b0;
        if (guard >= 2000) check("send_timeout", sent, PPI);
        if (mode == 5) begin
            do_reset();
            return;
        end
        if (mode == 4) begin
            repeat (4) tick();
            check("ovf_flag", int'(overflow_o), 1);
            check("ovf_valid", int'(pixel_valid_o), 1);
            check("ovf_interrupt", int'(interrupt_o), 1);
            pixel_ready_i = 1'b1;
            repeat (30) tick();
            check("ovf_count", hs_img, DEPTH);
`ifndef JITTER_LFSR_EN
            check("ovf_last_value", int'(last_hs_pix), 15);
`endif
            check("ovf_empty", int'(pixel_valid_o), 0);
            check("ovf_still_busy", int'(busy_o), 1);
            do_reset();
            return;
        end
        guard = 0;
        while (busy_o && guard < 500) begin
            pixel_ready_i = (mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
            pixel_valid_i = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            guard++;
        end
        pixel_valid_i = 1'b0;
        check("drain_timeout", int'(busy_o), 0);
        check("frame_len", hs_img, PPI);
        if (mode == 2) check("clamp_value", int'(last_hs_pix), lit);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        for (int i = 0; i < 11; i++) run_image(1, 8'd0, 8'd128, 8'(i * PPI), 0);
`ifndef JITTER_LFSR_EN
        run_image(2, 8'd100, 8'd255, 8'd200, 255);
        run_image(2, 8'h80, 8'd128, 8'd10, 0);
        run_image(2, 8'd5, 8'd0, 8'd128, 133);
`endif
        run_image(3, 8'($urandom), 8'($urandom), 8'd0, 0);
        for (int i = 0; i < 8; i++) run_image(0, 8'($urandom), 8'($urandom), 8'd0, 0);
        run_image(4, 8'd0, 8'd128, 8'd0, 0);
        run_image(0, 8'($urandom), 8'($urandom), 8'd0, 0);
        run_image(5, 8'($urandom), 8'($urandom), 8'd0, 0);
        for (int i = 0; i < 3; i++) run_image(0, 8'($urandom), 8'($urandom), 8'd0, 0);
        repeat (3) tick();
        check("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
